pipe_sum_prod: RTL and testbench
================================

// Module: pipe_sum_prod
// PURPOSE
// - Parametrised 3-stage pipeline computing a 4-operand sum (a+b+c+d) and the product a*b for one input beat.
// - Carries valid/ready flow control end to end, so upstream and downstream may stall freely.
// - Internal bubbles collapse; an input beat is never dropped or duplicated.
// - Sits between operand-fetch logic and the result/compare consumer; it is the general form of the fixed 1-bit sum/product pipe.
// PARAMETERS
// - WIDTH   8  operand width in bits; legal range 2..32.
// - SIGNED  0  0: operands unsigned, zero-extended. 1: two's complement, sign-extended.
// PORTS
// - clock      in   1          rising-edge clock
// - reset_n    in   1          asynchronous, active-low reset
// - in_valid   in   1          input beat present on a/b/c/d
// - in_ready   out  1          pipe accepts the beat this cycle
// - a,b,c,d    in   WIDTH      operands; sampled only when in_valid && in_ready
// - out_valid  out  1          result beat present
// - out_ready  in   1          consumer accepts the result this cycle
// - out_sum    out  WIDTH+2    a+b+c+d, exact (no overflow possible)
// - out_prod   out  2*WIDTH    a*b, exact
// - out_gt     out  1          out_prod > out_sum; comparison is signed when SIGNED=1
// BEHAVIOUR
// - Reset: one clock, reset is asynchronous and active-low.
//   - All valid bits, out_sum, out_prod and every internal data register clear to 0 immediately.
//   - Consequently out_valid=0 and out_gt=0 during reset.
//   - Reset mid-stream discards all in-flight beats; no partial results.
// - Pipeline (stage k holds v_k plus data):
//   - S1: s1 = a+b (WIDTH+1 bits); c1 = c; d1 = d; p1 = a*b.
//   - S2: s2 = s1+c1 (WIDTH+2 bits); d2 = d1; p2 = p1.
//   - S3: out_sum = s2+d2; out_prod = p2; v3 drives out_valid.
//   - Extension to result width happens before each add: sign-extend when SIGNED=1, otherwise zero-extend.
// - Latency: 3 cycles from accepted input to out_valid when no stall occurs. Throughput is 1 beat/cycle.
// - Flow control:
//   - rdy3 = !v3 || out_ready
//   - rdy2 = !v2 || rdy3
//   - rdy1 = !v1 || rdy2
//   - in_ready = rdy1
// - Stage k loads when rdy_k is high:
//   - v_k takes the upstream valid.
//   - Data loads only when the upstream valid is 1; otherwise data holds. Bubbles carry no data update.
// - Output stability: while out_valid && !out_ready, out_sum, out_prod and out_gt hold stable.
// - Bubble collapse: an empty stage accepts even while the stage below is stalled. A full pipe holds 3 beats.
// - Simultaneous accept and emit: a full pipe with out_ready=1 and in_valid=1 shifts by one. in_ready stays 1.
// - in_ready is combinational from out_ready and the valid bits. There is no combinational path from in_valid to out_*.
// - out_gt is combinational from the S3 registers only.
// STRUCTURE
// - Package pipe_sum_prod_pkg holds the width helpers:
//   - SUM_W(w) = w+2
//   - PROD_W(w) = 2*w
//   - function ext(x, signed_mode, to_w)
// - One sub-module, pipe_slice: a valid/ready register slice with parameter DW.
//   - Ports: clock, reset_n, up_valid, up_ready, up_data, dn_valid, dn_ready, dn_data.
//   - Instantiated three times.
//   - Arithmetic sits between the slices in the top level.
// TESTING
// - Run WIDTH=8 unless noted.
// 1 Reset then a=3,b=4,c=5,d=6, out_ready=1.
//   -> out_valid=1 exactly 3 cycles after accept; sum=18, prod=12, gt=0.
// 2 a=b=c=d=255, SIGNED=0 -> sum=1020 (10'h3FC), prod=65025, gt=1.
//   SIGNED=1 with all operands 8'h80 -> sum=-512, prod=+16384, gt=1.
// 3 Back-to-back beats 1..10 (a=b=c=d=i), out_ready held 1.
//   -> 10 consecutive out_valid cycles with sum=4i and prod=i*i; in_ready never drops.
// 4 out_ready=0 while streaming.
//   -> in_ready drops after exactly 3 accepts; out_* hold stable.
//   Raise out_ready -> beats emerge in order with none lost or duplicated.
// 5 Alternate in_valid 1/0 with out_ready 0 for 2 cycles.
//   -> bubbles collapse and 3 beats are held; order and values are preserved.
// 6 Assert reset_n=0 asynchronously mid-stream with 2 beats in flight.
//   -> out_valid=0 in the same cycle; after release, no stale beat appears and the next input returns after 3 cycles.

Source files
------------

// File: rtl/pipe_sum_prod_pkg.sv
// Width helpers and operand extension shared by the sum/product pipeline.
// Every extension is done through ext() so that signed and unsigned builds share one datapath.
package pipe_sum_prod_pkg;

    localparam int MAX_W = 128;

    function automatic int SUM_W(input int w);
        return w + 2;
    endfunction

    function automatic int PROD_W(input int w);
        return 2 * w;
    endfunction

    // Widens the low from_w bits of x to to_w bits; bits at and above to_w are zero.
    function automatic logic [MAX_W-1:0] ext(input logic [MAX_W-1:0] x,
                                             input bit              signed_mode,
                                             input int              from_w,
                                             input int              to_w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < from_w)
                r[i] = x[i];
            else if (i < to_w)
                r[i] = signed_mode & x[from_w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_sum_prod_slice.sv
// One valid/ready register stage: accepts whenever it is empty or its content leaves this cycle.
// Data only moves on real beats, so bubbles never disturb the held payload.
module pipe_slice #(
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [DW-1:0] up_data,
    output logic          dn_valid,
    input  logic          dn_ready,
    output logic [DW-1:0] dn_data
);

    logic          v_q;
    logic [DW-1:0] data_q;

    assign up_ready = !v_q || dn_ready;
    assign dn_valid = v_q;
    assign dn_data  = data_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the payload is reset too, not just the valid bit, so out_sum/out_prod read 0 in reset.
            v_q    <= 1'b0;
            data_q <= '0;
        end else if (up_ready) begin
            // NOTE: non-blocking assignments keep every stage sampling the pre-edge value of its neighbour.
            v_q <= up_valid;
            if (up_valid)
                data_q <= up_data;
        end
    end

endmodule

// File: rtl/pipe_sum_prod.sv
// Three-stage valid/ready pipeline producing a+b+c+d and a*b; arithmetic sits between the slices.
// out_gt is derived combinationally from the last stage's registers only.
module pipe_sum_prod
    import pipe_sum_prod_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic [WIDTH-1:0]         c,
    input  logic [WIDTH-1:0]         d,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SUM_W(WIDTH)-1:0]  out_sum,
    output logic [PROD_W(WIDTH)-1:0] out_prod,
    output logic                     out_gt
);

    localparam int S1_W = WIDTH + 1;
    localparam int SW   = SUM_W(WIDTH);
    localparam int PW   = PROD_W(WIDTH);
    localparam int CW   = PW + 2;
    localparam int D1_W = S1_W + 2 * WIDTH + PW;
    localparam int D2_W = SW + WIDTH + PW;
    localparam int D3_W = SW + PW;

    logic            v1, v2;
    logic            rdy2, rdy3;
    logic [D1_W-1:0] st1_in, st1_q;
    logic [D2_W-1:0] st2_in, st2_q;
    logic [D3_W-1:0] st3_in, st3_q;

    logic [S1_W-1:0]  s1_in, s1_q;
    logic [PW-1:0]    p1_in, p1_q, p2_q;
    logic [WIDTH-1:0] c1_q, d1_q, d2_q;
    logic [SW-1:0]    s2_in, s2_q, sum3_in;

    // Stage 1: the product is formed at full result width, so its low bits are exact for both signednesses.
    assign s1_in  = S1_W'(ext(MAX_W'(a), SIGNED, WIDTH, S1_W))
                  + S1_W'(ext(MAX_W'(b), SIGNED, WIDTH, S1_W));
    assign p1_in  = PW'(ext(MAX_W'(a), SIGNED, WIDTH, PW))
                  * PW'(ext(MAX_W'(b), SIGNED, WIDTH, PW));
    assign st1_in = {s1_in, c, d, p1_in};

    pipe_slice #(.DW(D1_W)) u_s1 (
        .clock    (clock),
        .reset_n  (reset_n),
        .up_valid (in_valid),
        .up_ready (in_ready),
        .up_data  (st1_in),
        .dn_valid (v1),
        .dn_ready (rdy2),
        .dn_data  (st1_q)
    );

    assign {s1_q, c1_q, d1_q, p1_q} = st1_q;
    assign s2_in  = SW'(ext(MAX_W'(s1_q), SIGNED, S1_W, SW))
                  + SW'(ext(MAX_W'(c1_q), SIGNED, WIDTH, SW));
    assign st2_in = {s2_in, d1_q, p1_q};

    pipe_slice #(.DW(D2_W)) u_s2 (
        .clock    (clock),
        .reset_n  (reset_n),
        .up_valid (v1),
        .up_ready (rdy2),
        .up_data  (st2_in),
        .dn_valid (v2),
        .dn_ready (rdy3),
        .dn_data  (st2_q)
    );

    assign {s2_q, d2_q, p2_q} = st2_q;
    assign sum3_in = s2_q + SW'(ext(MAX_W'(d2_q), SIGNED, WIDTH, SW));
    assign st3_in  = {sum3_in, p2_q};

    pipe_slice #(.DW(D3_W)) u_s3 (
        .clock    (clock),
        .reset_n  (reset_n),
        .up_valid (v2),
        .up_ready (rdy3),
        .up_data  (st3_in),
        .dn_valid (out_valid),
        .dn_ready (out_ready),
        .dn_data  (st3_q)
    );

    assign {out_sum, out_prod} = st3_q;

    // Both operands are widened past the larger result so the compare never wraps.
    logic [CW-1:0] prod_x, sum_x;
    assign prod_x = CW'(ext(MAX_W'(out_prod), SIGNED, PW, CW));
    assign sum_x  = CW'(ext(MAX_W'(out_sum), SIGNED, SW, CW));
    assign out_gt = SIGNED ? ($signed(prod_x) > $signed(sum_x)) : (prod_x > sum_x);

endmodule

// File: tb/tb_pipe_sum_prod.sv
// Directed bench for pipe_sum_prod: an unsigned and a signed instance share clock, reset and stimulus.
// Expected values are hand-computed constants or simple closed forms of the beat index.
module tb_pipe_sum_prod;

    localparam int W = 8;

    logic           clock     = 1'b0;
    logic           reset_n   = 1'b0;
    logic           in_valid  = 1'b0;
    logic           out_ready = 1'b1;
    logic [W-1:0]   a = '0, b = '0, c = '0, d = '0;

    logic           u_in_ready, u_out_valid, u_out_gt;
    logic [W+1:0]   u_out_sum;
    logic [2*W-1:0] u_out_prod;
    logic           s_in_ready, s_out_valid, s_out_gt;
    logic [W+1:0]   s_out_sum;
    logic [2*W-1:0] s_out_prod;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    pipe_sum_prod #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (u_in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (u_out_valid),
        .out_ready (out_ready),
        .out_sum   (u_out_sum),
        .out_prod  (u_out_prod),
        .out_gt    (u_out_gt)
    );

    pipe_sum_prod #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_sum   (s_out_sum),
        .out_prod  (s_out_prod),
        .out_gt    (s_out_gt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s failed", tag);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic put4(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] cv, input logic [W-1:0] dv);
        in_valid = v;
        a = av;
        b = bv;
        c = cv;
        d = dv;
        #1;
    endtask

    task automatic put(input logic v, input int x);
        put4(v, W'(x), W'(x), W'(x), W'(x));
    endtask

    // Beat i carries a=b=c=d=i on the unsigned instance.
    task automatic check_beat(input string tag, input int i);
        check({tag, "_valid"}, u_out_valid, 1);
        check({tag, "_sum"}, u_out_sum, 4 * i);
        check({tag, "_prod"}, u_out_prod, i * i);
        check({tag, "_gt"}, u_out_gt, (i * i > 4 * i) ? 1 : 0);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_valid", u_out_valid, 0);
        check("rst_sum", u_out_sum, 0);
        check("rst_prod", u_out_prod, 0);
        check("rst_gt", u_out_gt, 0);
        check("rst_s_valid", s_out_valid, 0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // Single beat, 3-cycle latency
        put4(1'b1, 8'd3, 8'd4, 8'd5, 8'd6);
        check("t1_ready", u_in_ready, 1);
        step();
        put(1'b0, 0);
        check("t1_lat1", u_out_valid, 0);
        step();
        check("t1_lat2", u_out_valid, 0);
        step();
        check("t1_valid", u_out_valid, 1);
        check("t1_sum", u_out_sum, 18);
        check("t1_prod", u_out_prod, 12);
        check("t1_gt", u_out_gt, 0);
        step();
        check("t1_drain", u_out_valid, 0);

        // Extreme operands on both instances
        put4(1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        step();
        put4(1'b1, 8'h80, 8'h80, 8'h80, 8'h80);
        step();
        put4(1'b1, 8'hFD, 8'd4, 8'd5, 8'd6);
        step();
        put(1'b0, 0);
        check("t2_max_sum", u_out_sum, 10'h3FC);
        check("t2_max_prod", u_out_prod, 65025);
        check("t2_max_gt", u_out_gt, 1);
        step();
        check("t2_neg_valid", s_out_valid, 1);
        check("t2_neg_sum", s_out_sum, 10'h200);
        check("t2_neg_prod", s_out_prod, 16'h4000);
        check("t2_neg_gt", s_out_gt, 1);
        step();
        check("t2_mix_s_sum", s_out_sum, 10'h00C);
        check("t2_mix_s_prod", s_out_prod, 16'hFFF4);
        check("t2_mix_s_gt", s_out_gt, 0);
        check("t2_mix_u_sum", u_out_sum, 268);
        check("t2_mix_u_prod", u_out_prod, 1012);
        check("t2_mix_u_gt", u_out_gt, 1);
        step();
        check("t2_drain", u_out_valid, 0);

        // Back-to-back beats 1..10
        for (int t = 0; t < 13; t++) begin
            if (t < 10) begin
                put(1'b1, t + 1);
                check("t3_ready", u_in_ready, 1);
            end else begin
                put(1'b0, 0);
            end
            step();
            if (t >= 2 && t <= 11)
                check_beat("t3_beat", t - 1);
            else
                check("t3_idle", u_out_valid, 0);
        end

        // Downstream stall: three accepts, then in_ready drops and outputs hold
        out_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            put(1'b1, 11 + t);
            check("t4_ready", u_in_ready, 1);
            step();
        end
        put(1'b1, 14);
        for (int t = 0; t < 3; t++) begin
            check("t4_full", u_in_ready, 0);
            check_beat("t4_hold", 11);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("t4_reopen", u_in_ready, 1);
        step();
        put(1'b0, 0);
        check_beat("t4_b12", 12);
        step();
        check_beat("t4_b13", 13);
        step();
        check_beat("t4_b14", 14);
        step();
        check("t4_drain", u_out_valid, 0);

        // Bubble collapse under stall
        out_ready = 1'b0;
        put(1'b1, 20);
        check("t5_r0", u_in_ready, 1);
        step();
        put(1'b0, 0);
        check("t5_r1", u_in_ready, 1);
        step();
        put(1'b1, 21);
        check("t5_r2", u_in_ready, 1);
        step();
        put(1'b0, 0);
        check("t5_r3", u_in_ready, 1);
        step();
        put(1'b1, 22);
        check("t5_r4", u_in_ready, 1);
        step();
        put(1'b1, 23);
        check("t5_full", u_in_ready, 0);
        check_beat("t5_hold0", 20);
        step();
        check("t5_full2", u_in_ready, 0);
        check_beat("t5_hold1", 20);
        put(1'b0, 0);
        out_ready = 1'b1;
        #1;
        check("t5_reopen", u_in_ready, 1);
        step();
        check_beat("t5_b21", 21);
        step();
        check_beat("t5_b22", 22);
        step();
        check("t5_drain", u_out_valid, 0);

        // Asynchronous reset with two beats in flight
        put(1'b1, 30);
        step();
        put(1'b1, 31);
        step();
        put(1'b0, 0);
        step();
        check_beat("t6_pre", 30);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_async_valid", u_out_valid, 0);
        check("t6_async_sum", u_out_sum, 0);
        check("t6_async_prod", u_out_prod, 0);
        step();
        step();
        reset_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            step();
            check("t6_no_stale", u_out_valid, 0);
        end
        put(1'b1, 40);
        step();
        put(1'b0, 0);
        check("t6_lat1", u_out_valid, 0);
        step();
        check("t6_lat2", u_out_valid, 0);
        step();
        check_beat("t6_b40", 40);
        step();
        check("t6_drain", u_out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
